// File: rtl/gpio_bus_arb.sv
// gpio_bus_arb -- two-master arbiter in front of the single GPIO register port.
//
// One transaction is outstanding at a time. In IDLE a winner is chosen
// (round-robin, or master 0 first when FIXED_PRIO=1). Its request is latched
// and presented to the slave (REQ). The slave response is then routed back to
// that master (RSP). A 16-bit watchdog forces an error completion (ERR) if the
// slave does not finish within TIMEOUT cycles of REQ+RSP.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   mN_addr_i/data_i/sel_i/we_i master N request fields (N = 0, 1)
//   mN_req_valid_i/req_ready_o  master N request handshake
//   mN_rsp_valid_o/rsp_ready_i  master N response handshake
//   mN_data_o, mN_err_o         master N read data, timeout error flag
//   s_addr_o/data_o/sel_o/we_o  slave request fields (from latched registers)
//   s_req_valid_o/req_ready_i   slave request handshake
//   s_rsp_valid_i/rsp_ready_o   slave response handshake
//   s_data_i                    slave read data
module gpio_bus_arb #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  output logic        m0_rsp_valid_o,
  input  logic        m0_rsp_ready_i,
  output logic [31:0] m0_data_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  output logic        m1_rsp_valid_o,
  input  logic        m1_rsp_ready_i,
  output logic [31:0] m1_data_o,
  output logic        m1_err_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_req_valid_o,
  input  logic        s_req_ready_i,
  input  logic        s_rsp_valid_i,
  output logic        s_rsp_ready_o,
  input  logic [31:0] s_data_i
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_e;

  // Last cycle of the REQ+RSP budget: leaving it without completion means ERR.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;    // master favoured on contention (round-robin)
  logic        gnt_q, gnt_d;    // granted master ID
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;

  logic win1;         // master 1 wins arbitration this cycle
  logic gnt_rsp_rdy;  // rsp_ready of the granted master

  assign win1        = m1_req_valid_i & (~m0_req_valid_i | (~FIXED_PRIO & ptr_q));
  assign gnt_rsp_rdy = gnt_q ? m1_rsp_ready_i : m0_rsp_ready_i;

  assign s_addr_o = addr_q;
  assign s_data_o = data_q;
  assign s_sel_o  = sel_q;
  assign s_we_o   = we_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_d          = gnt_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    data_d         = data_q;
    sel_d          = sel_q;
    we_d           = we_q;
    m0_req_ready_o = 1'b0;
    m1_req_ready_o = 1'b0;
    m0_rsp_valid_o = 1'b0;
    m1_rsp_valid_o = 1'b0;
    m0_data_o      = '0;
    m1_data_o      = '0;
    m0_err_o       = 1'b0;
    m1_err_o       = 1'b0;
    s_req_valid_o  = 1'b0;
    s_rsp_ready_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Acceptance is held off while reset is asserted so outputs stay 0.
        if (rst_n && (m0_req_valid_i || m1_req_valid_i)) begin
          gnt_d   = win1;
          addr_d  = win1 ? m1_addr_i : m0_addr_i;
          data_d  = win1 ? m1_data_i : m0_data_i;
          sel_d   = win1 ? m1_sel_i  : m0_sel_i;
          we_d    = win1 ? m1_we_i   : m0_we_i;
          cnt_d   = '0;
          state_d = REQ;
          if (win1) m1_req_ready_o = 1'b1;
          else      m0_req_ready_o = 1'b1;
        end
      end

      REQ: begin
        s_req_valid_o = 1'b1;
        cnt_d         = cnt_q + 16'd1;
        if (cnt_q == CNT_LAST)  state_d = ERR;
        else if (s_req_ready_i) state_d = RSP;
      end

      RSP: begin
        s_rsp_ready_o = gnt_rsp_rdy;
        cnt_d         = cnt_q + 16'd1;
        if (gnt_q) begin
          m1_rsp_valid_o = s_rsp_valid_i;
          m1_data_o      = s_data_i;
        end else begin
          m0_rsp_valid_o = s_rsp_valid_i;
          m0_data_o      = s_data_i;
        end
        // A response in the final budget cycle still completes normally.
        if (s_rsp_valid_i && gnt_rsp_rdy) begin
          state_d = IDLE;
          if (!FIXED_PRIO) ptr_d = ~gnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end
      end

      ERR: begin
        if (gnt_q) begin
          m1_rsp_valid_o = 1'b1;
          m1_err_o       = 1'b1;
        end else begin
          m0_rsp_valid_o = 1'b1;
          m0_err_o       = 1'b1;
        end
        if (gnt_rsp_rdy) begin
          state_d = IDLE;
          if (!FIXED_PRIO) ptr_d = ~gnt_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      // NOTE: the latched request is reset too, because s_* outputs are driven straight from it.
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Self-checking bench for gpio_bus_arb: a round-robin instance and a
// fixed-priority instance (both TIMEOUT=8) share all inputs.
module tb_gpio_bus_arb;

  localparam int TO = 8;

  typedef struct packed {
    logic [1:0]       rdy;
    logic [1:0]       rv;
    logic [1:0]       er;
    logic             sreq;
    logic             srsp;
    logic [1:0][31:0] d;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0]       sel;
    logic             we;
  } out_t;

  localparam int W = $bits(out_t);

  typedef struct packed {
    logic warm;             // complete one m0 transaction first
    logic v0, v1;           // request valids
    logic er0, er1;         // expected req_ready, round-robin instance
    logic ef0, ef1;         // expected req_ready, fixed-priority instance
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_addr[2], m_data[2];
  logic [3:0]  m_sel[2];
  logic        m_we[2], m_valid[2], m_rsp_ready[2];
  logic        s_req_ready, s_rsp_valid;
  logic [31:0] s_data_i;
  logic        use_rnd;
  logic [31:0] rnd_data;

  logic        rdy_rr[2], rv_rr[2], er_rr[2];
  logic [31:0] d_rr[2];
  logic [31:0] sa_rr, sd_rr;
  logic [3:0]  ss_rr;
  logic        sw_rr, sqv_rr, srr_rr;
  logic        rdy_fp[2], rv_fp[2], er_fp[2];
  logic [31:0] d_fp[2];
  logic [31:0] sa_fp, sd_fp;
  logic [3:0]  ss_fp;
  logic        sw_fp, sqv_fp, srr_fp;

  out_t act_rr, act_fp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Slave read data: random in the random phase, else a fixed function of address.
  always_comb s_data_i = use_rnd ? rnd_data : (sa_rr ^ 32'h5A5A_0000);

  gpio_bus_arb #(.FIXED_PRIO(1'b0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_data[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_req_valid_i(m_valid[0]), .m0_req_ready_o(rdy_rr[0]), .m0_rsp_valid_o(rv_rr[0]),
    .m0_rsp_ready_i(m_rsp_ready[0]), .m0_data_o(d_rr[0]), .m0_err_o(er_rr[0]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_data[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_req_valid_i(m_valid[1]), .m1_req_ready_o(rdy_rr[1]), .m1_rsp_valid_o(rv_rr[1]),
    .m1_rsp_ready_i(m_rsp_ready[1]), .m1_data_o(d_rr[1]), .m1_err_o(er_rr[1]),
    .s_addr_o(sa_rr), .s_data_o(sd_rr), .s_sel_o(ss_rr), .s_we_o(sw_rr),
    .s_req_valid_o(sqv_rr), .s_req_ready_i(s_req_ready), .s_rsp_valid_i(s_rsp_valid),
    .s_rsp_ready_o(srr_rr), .s_data_i(s_data_i)
  );

  gpio_bus_arb #(.FIXED_PRIO(1'b1), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_data[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_req_valid_i(m_valid[0]), .m0_req_ready_o(rdy_fp[0]), .m0_rsp_valid_o(rv_fp[0]),
    .m0_rsp_ready_i(m_rsp_ready[0]), .m0_data_o(d_fp[0]), .m0_err_o(er_fp[0]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_data[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_req_valid_i(m_valid[1]), .m1_req_ready_o(rdy_fp[1]), .m1_rsp_valid_o(rv_fp[1]),
    .m1_rsp_ready_i(m_rsp_ready[1]), .m1_data_o(d_fp[1]), .m1_err_o(er_fp[1]),
    .s_addr_o(sa_fp), .s_data_o(sd_fp), .s_sel_o(ss_fp), .s_we_o(sw_fp),
    .s_req_valid_o(sqv_fp), .s_req_ready_i(s_req_ready), .s_rsp_valid_i(s_rsp_valid),
    .s_rsp_ready_o(srr_fp), .s_data_i(s_data_i)
  );

  always_comb begin
    act_rr      = '0;
    act_rr.rdy  = {rdy_rr[1], rdy_rr[0]};
    act_rr.rv   = {rv_rr[1], rv_rr[0]};
    act_rr.er   = {er_rr[1], er_rr[0]};
    act_rr.sreq = sqv_rr;
    act_rr.srsp = srr_rr;
    act_rr.d    = {d_rr[1], d_rr[0]};
    act_rr.addr = sa_rr;
    act_rr.data = sd_rr;
    act_rr.sel  = ss_rr;
    act_rr.we   = sw_rr;
    act_fp      = '0;
    act_fp.rdy  = {rdy_fp[1], rdy_fp[0]};
    act_fp.rv   = {rv_fp[1], rv_fp[0]};
    act_fp.er   = {er_fp[1], er_fp[0]};
    act_fp.sreq = sqv_fp;
    act_fp.srsp = srr_fp;
    act_fp.d    = {d_fp[1], d_fp[0]};
    act_fp.addr = sa_fp;
    act_fp.data = sd_fp;
    act_fp.sel  = ss_fp;
    act_fp.we   = sw_fp;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_data[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0;
      m_valid[m] = 1'b0; m_rsp_ready[m] = 1'b0;
    end
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    use_rnd     = 1'b0;
    rnd_data    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic we);
    m_addr[m] = a; m_data[m] = d; m_sel[m] = s; m_we[m] = we; m_valid[m] = 1'b1;
  endtask

  // Unchecked read by master m against an always-ready slave (starts and ends in IDLE).
  task automatic run_txn(input int m);
    set_req(m, 32'h10 + 32'(m), 32'h0, 4'hF, 1'b0);
    tick();
    m_valid[m] = 1'b0;
    s_req_ready = 1'b1;
    tick();
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b1;
    m_rsp_ready[0] = 1'b1;
    m_rsp_ready[1] = 1'b1;
    tick();
    s_rsp_valid = 1'b0;
    m_rsp_ready[0] = 1'b0;
    m_rsp_ready[1] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    out_t e;
    int   cnt;
    int   ord;
    int   seen;
    int   q[$];
    bit   found;

    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    mid();
    check("reset rr", act_rr, '0);
    check("reset fp", act_fp, '0);

    // ---------------- arbitration table ----------------
    foreach (vt[i]) begin
      do_reset();
      if (vt[i].warm) run_txn(0);
      m_valid[0] = vt[i].v0;
      m_valid[1] = vt[i].v1;
      mid();
      check($sformatf("arb rr v%0d", i), W'(act_rr.rdy), W'({vt[i].er1, vt[i].er0}));
      check($sformatf("arb fp v%0d", i), W'(act_fp.rdy), W'({vt[i].ef1, vt[i].ef0}));
      tick();
    end

    // ---------------- single write, minimum latency ----------------
    do_reset();
    set_req(0, 32'h4, 32'h0000_00A5, 4'hF, 1'b1);
    mid();
    e = '0; e.rdy = 2'b01;
    check("wr accept", act_rr, e);
    tick();
    m_valid[0] = 1'b0;
    s_req_ready = 1'b1;
    mid();
    e = '0; e.sreq = 1'b1; e.addr = 32'h4; e.data = 32'hA5; e.sel = 4'hF; e.we = 1'b1;
    check("wr slave req", act_rr, e);
    tick();
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b1;
    m_rsp_ready[0] = 1'b1;
    mid();
    e.sreq = 1'b0; e.srsp = 1'b1; e.rv = 2'b01; e.d[0] = 32'h5A5A_0004;
    check("wr response", act_rr, e);
    tick();
    s_rsp_valid = 1'b0;
    m_rsp_ready[0] = 1'b0;
    mid();
    e = '0; e.addr = 32'h4; e.data = 32'hA5; e.sel = 4'hF; e.we = 1'b1;
    check("wr back idle", act_rr, e);
    tick();

    // ---------------- contention: RR order, then fixed priority ----------------
    do_reset();
    set_req(0, 32'h0, 32'h0, 4'hF, 1'b0);
    set_req(1, 32'h4, 32'h0, 4'hF, 1'b0);
    s_req_ready = 1'b1;
    s_rsp_valid = 1'b1;
    m_rsp_ready[0] = 1'b1;
    m_rsp_ready[1] = 1'b1;
    cnt = 0;
    seen = 0;
    for (int c = 0; c < 20 && q.size() < 4; c++) begin
      mid();
      if (rdy_rr[0]) q.push_back(0);
      if (rdy_rr[1]) q.push_back(1);
      if (rv_rr[1]) begin
        seen++;
        check("rr m1 read data", W'(d_rr[1]), W'(32'h5A5A_0004));
      end
      if (rv_rr[0]) check("rr m0 read data", W'(d_rr[0]), W'(32'h5A5A_0000));
      if (rdy_fp[1]) cnt++;
      tick();
    end
    ord = 32'hF;
    if (q.size() == 4) ord = (q[0] << 3) | (q[1] << 2) | (q[2] << 1) | q[3];
    check("rr grant order", W'(ord), W'(4'b0101));
    check("rr m1 responses seen", W'(seen != 0), W'(1));
    check("fp m1 starved while m0 holds", W'(cnt), W'(0));
    m_valid[0] = 1'b0;
    found = 1'b0;
    cnt = -1;
    for (int w = 0; w < 6 && !found; w++) begin
      mid();
      if (rdy_fp[1]) begin found = 1'b1; cnt = w; end
      tick();
    end
    check("fp m1 grant at first idle", W'(cnt), W'(2));
    clear_inputs();
    tick();

    // ---------------- timeout ----------------
    do_reset();
    set_req(0, 32'h8, 32'h0, 4'hF, 1'b0);
    tick();
    m_valid[0] = 1'b0;
    s_req_ready = 1'b1;
    cnt = 0;
    for (int j = 0; j < TO; j++) begin
      mid();
      if (rv_rr[0] || er_rr[0]) cnt++;
      tick();
    end
    check("to no early rsp", W'(cnt), W'(0));
    mid();
    e = '0; e.rv = 2'b01; e.er = 2'b01; e.addr = 32'h8; e.sel = 4'hF;
    check("to error rsp", act_rr, e);
    tick();
    mid();
    check("to error held", act_rr, e);
    m_rsp_ready[0] = 1'b1;
    tick();
    m_rsp_ready[0] = 1'b0;
    s_rsp_valid = 1'b1;
    mid();
    e = '0; e.addr = 32'h8; e.sel = 4'hF;
    check("to late rsp ignored", act_rr, e);
    m_valid[0] = 1'b1;
    m_valid[1] = 1'b1;
    #1;
    check("to ptr rotated", W'(act_rr.rdy), W'(2'b10));
    tick();
    clear_inputs();

    // ---------------- response backpressure on m1 ----------------
    do_reset();
    run_txn(0);
    set_req(1, 32'hC, 32'h0, 4'h3, 1'b0);
    mid();
    check("bp m1 accept", W'(act_rr.rdy), W'(2'b10));
    tick();
    m_valid[1] = 1'b0;
    s_req_ready = 1'b1;
    tick();
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      mid();
      if (!srr_rr && rv_rr[1] && !rv_rr[0] && d_rr[1] == 32'h5A5A_000C) cnt++;
      tick();
    end
    check("bp stall cycles", W'(cnt), W'(3));
    m_rsp_ready[1] = 1'b1;
    mid();
    check("bp complete", W'({srr_rr, rv_rr[1]}), W'(2'b11));
    tick();
    clear_inputs();
    m_valid[0] = 1'b1;
    m_valid[1] = 1'b1;
    mid();
    check("bp ptr back to m0", W'(act_rr.rdy), W'(2'b01));
    tick();
    clear_inputs();

    // ---------------- reset mid-transaction ----------------
    do_reset();
    run_txn(0);
    set_req(1, 32'hC, 32'h0, 4'hF, 1'b0);
    tick();
    m_valid[0] = 1'b1;
    m_valid[1] = 1'b1;
    s_req_ready = 1'b1;
    tick();
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b1;
    mid();
    check("rst in rsp", W'(rv_rr[1]), W'(1));
    rst_n = 1'b0;
    tick();
    mid();
    check("rst outputs rr", act_rr, '0);
    check("rst outputs fp", act_fp, '0);
    rst_n = 1'b1;
    #1;
    check("rst first grant m0", W'(act_rr.rdy), W'(2'b01));
    tick();
    clear_inputs();

    // ---------------- randomized run vs reference model ----------------
    begin
      bit          busy, owner, ptr, hang, pend[2], win, last;
      int          phase, t_acc, cyc;
      logic [31:0] la, ld;
      logic [3:0]  ls;
      logic        lw;
      do_reset();
      busy = 0; owner = 0; ptr = 0; hang = 0; pend[0] = 0; pend[1] = 0;
      phase = 0; t_acc = 0; cyc = 0; la = '0; ld = '0; ls = '0; lw = 1'b0;
      use_rnd = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        for (int m = 0; m < 2; m++) begin
          if (!pend[m] && $urandom_range(0, 3) == 0) begin
            pend[m] = 1;
            m_addr[m] = $urandom; m_data[m] = $urandom;
            m_sel[m] = 4'($urandom); m_we[m] = 1'($urandom);
          end else if (pend[m] && $urandom_range(0, 31) == 0) begin
            pend[m] = 0;
          end
          m_valid[m] = pend[m];
          m_rsp_ready[m] = ($urandom_range(0, 3) != 0);
        end
        s_req_ready = 1'($urandom);
        s_rsp_valid = !hang && ($urandom_range(0, 1) == 1);
        rnd_data = $urandom;
        mid();

        win = m_valid[1] && (!m_valid[0] || ptr);
        e = '0; e.addr = la; e.data = ld; e.sel = ls; e.we = lw;
        if (!busy) begin
          if (m_valid[0] || m_valid[1]) e.rdy[win] = 1'b1;
        end else if (phase == 0) begin
          e.sreq = 1'b1;
        end else if (phase == 1) begin
          e.srsp = m_rsp_ready[owner];
          e.rv[owner] = s_rsp_valid;
          e.d[owner] = s_data_i;
        end else begin
          e.rv[owner] = 1'b1;
          e.er[owner] = 1'b1;
        end
        check($sformatf("rand c%0d", c), act_rr, e);

        last = (cyc == t_acc + TO);
        if (!busy) begin
          if (m_valid[0] || m_valid[1]) begin
            busy = 1; owner = win; phase = 0; t_acc = cyc; pend[win] = 0;
            la = m_addr[win]; ld = m_data[win]; ls = m_sel[win]; lw = m_we[win];
            hang = ($urandom_range(0, 5) == 0);
          end
        end else if (phase == 0) begin
          if (last) phase = 2;
          else if (s_req_ready) phase = 1;
        end else if (phase == 1) begin
          if (s_rsp_valid && m_rsp_ready[owner]) begin busy = 0; ptr = !owner; hang = 0; end
          else if (last) phase = 2;
        end else begin
          if (m_rsp_ready[owner]) begin busy = 0; ptr = !owner; hang = 0; end
        end
        cyc++;
        tick();
      end
      clear_inputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
